// File: rtl/regfile_cmd_master_if.sv
// ---------------------------------------------------------------------------
// regfile_cmd_master_if
// Bundles the three signal groups around regfile_cmd_master:
//   cmd_*  : command channel from the control sequencer (valid/ready)
//   rf_*   : requester side of the two-read/one-write register file
//   rsp_*  : one-cycle completion response
// Modports:
//   master : the command master block (drives cmd_ready, rf_* requests, rsp_*)
//   slave  : the environment (sequencer + register file)
// ---------------------------------------------------------------------------
interface regfile_cmd_master_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
  // command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_rs1;
  logic [ADDR_WIDTH-1:0] cmd_rs2;
  logic [ADDR_WIDTH-1:0] cmd_rd;
  logic [DATA_WIDTH-1:0] cmd_imm;
  // register file requests
  logic [ADDR_WIDTH-1:0] rf_rad1;
  logic                  rf_ren1;
  logic [ADDR_WIDTH-1:0] rf_rad2;
  logic                  rf_ren2;
  logic [ADDR_WIDTH-1:0] rf_wad1;
  logic                  rf_wen1;
  logic [DATA_WIDTH-1:0] rf_din;
  // register file returns
  logic [DATA_WIDTH-1:0] rf_dout1;
  logic [DATA_WIDTH-1:0] rf_dout2;
  logic                  rf_collision;
  // response
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_carry;
  logic                  rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm,
    input  rf_dout1, rf_dout2, rf_collision,
    output cmd_ready,
    output rf_rad1, rf_ren1, rf_rad2, rf_ren2, rf_wad1, rf_wen1, rf_din,
    output rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm,
    output rf_dout1, rf_dout2, rf_collision,
    input  cmd_ready,
    input  rf_rad1, rf_ren1, rf_rad2, rf_ren2, rf_wad1, rf_wen1, rf_din,
    input  rsp_valid, rsp_data, rsp_carry, rsp_err
  );
endinterface

// File: rtl/regfile_cmd_master.sv
// ---------------------------------------------------------------------------
// regfile_cmd_master
// Executes one register-transfer command at a time (ADD, SUB, MOV, LDI)
// against a two-read/one-write register file: reads the sources, computes
// the result, writes it back and emits a one-cycle response. Reads that the
// register file flags with rf_collision are re-issued up to MAX_RETRY times;
// after that the command ends with rsp_err=1 and no write.
//
// Ports:
//   clk       : clock, all state changes on posedge
//   resetn    : asynchronous active-low reset
//   bus       : regfile_cmd_master_if.master (cmd_*, rf_*, rsp_* groups)
//   dbg_state : current FSM state (IDLE=0, READ=1, WAIT=2, WRITE=3, RESP=4)
//
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only in IDLE (and never in reset);
// cmd_* fields are sampled only at that edge and ignored at all other times.
// ---------------------------------------------------------------------------
module regfile_cmd_master #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_RETRY  = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  regfile_cmd_master_if.master bus,
  output logic [2:0]           dbg_state
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  carry_q;
  logic                  err_q;
  logic [RW-1:0]         retry_q;

  logic                  accept;
  logic                  two_src;
  logic [DATA_WIDTH:0]   sum_w;
  logic [DATA_WIDTH:0]   diff_w;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;

  assign accept    = bus.cmd_valid && bus.cmd_ready;
  assign two_src   = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign dbg_state = state_q;

  // Bit DATA_WIDTH of the zero-extended difference is the unsigned borrow.
  assign sum_w  = {1'b0, bus.rf_dout1} + {1'b0, bus.rf_dout2};
  assign diff_w = {1'b0, bus.rf_dout1} - {1'b0, bus.rf_dout2};

  always_comb begin
    alu_res   = bus.rf_dout1;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = sum_w[DATA_WIDTH-1:0];
        alu_carry = sum_w[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_w[DATA_WIDTH-1:0];
        alu_carry = diff_w[DATA_WIDTH];
      end
      default: begin
        alu_res   = bus.rf_dout1;
        alu_carry = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (bus.cmd_op == OP_LDI) ? S_WRITE : S_READ;
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.rf_collision)          state_d = S_WRITE;
        else if (retry_q < RETRY_LIMIT) state_d = S_READ;
        else                            state_d = S_RESP;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Captured command, retry counter and result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q     <= OP_ADD;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      retry_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q     <= bus.cmd_op;
            rs1_q    <= bus.cmd_rs1;
            rs2_q    <= bus.cmd_rs2;
            rd_q     <= bus.cmd_rd;
            // LDI skips the read phase, so its result is the immediate itself.
            result_q <= (bus.cmd_op == OP_LDI) ? bus.cmd_imm : '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            retry_q  <= '0;
          end
        end
        S_WAIT: begin
          if (!bus.rf_collision) begin
            result_q <= alu_res;
            carry_q  <= alu_carry;
          end else if (retry_q < RETRY_LIMIT) begin
            retry_q <= retry_q + RW'(1);
          end else begin
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b1;
          end
        end
        S_RESP:  retry_q <= '0;
        default: ;
      endcase
    end
  end

  // Outputs decode purely from state; everything idles at zero.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.rf_rad1   = '0;
    bus.rf_ren1   = 1'b0;
    bus.rf_rad2   = '0;
    bus.rf_ren2   = 1'b0;
    bus.rf_wad1   = '0;
    bus.rf_wen1   = 1'b0;
    bus.rf_din    = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_carry = 1'b0;
    bus.rsp_err   = 1'b0;
    case (state_q)
      S_IDLE: bus.cmd_ready = resetn;
      S_READ: begin
        bus.rf_ren1 = 1'b1;
        bus.rf_rad1 = rs1_q;
        if (two_src) begin
          bus.rf_ren2 = 1'b1;
          bus.rf_rad2 = rs2_q;
        end
      end
      S_WRITE: begin
        bus.rf_wen1 = 1'b1;
        bus.rf_wad1 = rd_q;
        bus.rf_din  = result_q;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = result_q;
        bus.rsp_carry = carry_q;
        bus.rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_regfile_cmd_master
// Bench for regfile_cmd_master: a behavioural register file with scripted
// read collisions, a directed vector table, reset corner cases and a
// randomized phase checked against a reference model of the command rules.
// ---------------------------------------------------------------------------
module tb_regfile_cmd_master;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int MR = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  regfile_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  regfile_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_RETRY(MR)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus.master),
    .dbg_state(dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- register file model ----------------
  logic [DW-1:0] rf_mem [32];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  int            coll_target = 0;
  int            read_idx = 0;

  // Reads issued for the current command are numbered from 0; the first
  // coll_target of them come back flagged with collision and garbage data.
  always @(posedge clk) begin
    if (pre_we) rf_mem[pre_addr] <= pre_data;
    else if (bus.rf_wen1) rf_mem[bus.rf_wad1] <= bus.rf_din;
    if (bus.cmd_valid && bus.cmd_ready) read_idx <= 0;
    else if (bus.rf_ren1 || bus.rf_ren2) read_idx <= read_idx + 1;
    if ((bus.rf_ren1 || bus.rf_ren2) && read_idx >= coll_target) begin
      bus.rf_collision <= 1'b0;
      bus.rf_dout1 <= bus.rf_ren1 ? rf_mem[bus.rf_rad1] : DW'($urandom);
      bus.rf_dout2 <= bus.rf_ren2 ? rf_mem[bus.rf_rad2] : DW'($urandom);
    end else begin
      bus.rf_collision <= bus.rf_ren1 || bus.rf_ren2;
      bus.rf_dout1 <= DW'($urandom);
      bus.rf_dout2 <= DW'($urandom);
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] ref_mem [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic idle_cmd_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_op  = 2'($urandom);
    bus.cmd_rs1 = AW'($urandom);
    bus.cmd_rs2 = AW'($urandom);
    bus.cmd_rd  = AW'($urandom);
    bus.cmd_imm = DW'($urandom);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] rs1, rs2, rd,
                         input logic [DW-1:0] imm, input int ncoll,
                         input logic [DW-1:0] e_data, input logic e_carry, e_err,
                         input int e_lat);
    int lat, n_r1, n_r2, n_w, bad, stray, e_reads;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data, r_data;
    logic r_carry, r_err;
    lat = 99; n_r1 = 0; n_r2 = 0; n_w = 0; bad = 0; stray = 0;
    w_addr = '0; w_data = '0; r_data = '0; r_carry = 1'b0; r_err = 1'b0;
    @(negedge clk);
    check("cmd_ready_idle", bus.cmd_ready, 1);
    check("rsp_valid_idle", bus.rsp_valid, 0);
    coll_target = ncoll;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rs1 = rs1;
    bus.cmd_rs2 = rs2; bus.cmd_rd = rd; bus.cmd_imm = imm;
    @(posedge clk);
    #1 idle_cmd_inputs();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.rf_ren1) begin n_r1++; if (bus.rf_rad1 !== rs1) bad++; end
      else if (bus.rf_rad1 !== '0) stray++;
      if (bus.rf_ren2) begin n_r2++; if (bus.rf_rad2 !== rs2) bad++; end
      else if (bus.rf_rad2 !== '0) stray++;
      if (bus.rf_wen1) begin n_w++; w_addr = bus.rf_wad1; w_data = bus.rf_din; end
      else if (bus.rf_wad1 !== '0 || bus.rf_din !== '0) stray++;
      if ((bus.rf_ren1 || bus.rf_ren2) && bus.rf_wen1) stray++;
      if (bus.cmd_ready) stray++;
      if (bus.rsp_valid) begin
        lat = k; r_data = bus.rsp_data; r_carry = bus.rsp_carry; r_err = bus.rsp_err;
        break;
      end else if (bus.rsp_data !== '0 || bus.rsp_carry || bus.rsp_err) stray++;
    end
    if (op == OP_LDI) e_reads = 0;
    else if (e_err)   e_reads = MR + 1;
    else              e_reads = ncoll + 1;
    check("latency", lat, e_lat);
    check("rsp_data", r_data, e_data);
    check("rsp_carry", r_carry, e_carry);
    check("rsp_err", r_err, e_err);
    check("write_count", n_w, e_err ? 0 : 1);
    if (!e_err) begin
      check("wad1", w_addr, rd);
      check("din", w_data, e_data);
    end
    check("ren1_count", n_r1, e_reads);
    check("ren2_count", n_r2, (op == OP_ADD || op == OP_SUB) ? e_reads : 0);
    check("read_addr", bad, 0);
    check("idle_outputs", stray, 0);
  endtask

  // Reset asserted cyc cycles after an ADD is accepted (1=READ, 2=WAIT).
  task automatic reset_mid(input int cyc);
    int n_w;
    n_w = 0;
    preload(5'd21, 16'd7);
    preload(5'd22, 16'd9);
    @(negedge clk);
    coll_target = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_ADD; bus.cmd_rs1 = 5'd21;
    bus.cmd_rs2 = 5'd22; bus.cmd_rd = 5'd23; bus.cmd_imm = '0;
    @(posedge clk);
    #1 idle_cmd_inputs();
    repeat (cyc) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_ready", bus.cmd_ready, 0);
    check("midrst_rf", {bus.rf_ren1, bus.rf_ren2, bus.rf_wen1, bus.rf_rad1,
                        bus.rf_rad2, bus.rf_wad1, bus.rf_din}, 0);
    check("midrst_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_err}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.rf_wen1 || bus.rf_ren1 || bus.rsp_valid) n_w++;
    end
    check("midrst_no_activity", n_w, 0);
    check("midrst_ready_after", bus.cmd_ready, 1);
  endtask

  // Reference model: result of a command from the register contents.
  task automatic model(input logic [1:0] op, input logic [AW-1:0] rs1, rs2, rd,
                       input logic [DW-1:0] imm, input int ncoll,
                       output logic [DW-1:0] data, output logic carry, err,
                       output int lat);
    int a, b, s;
    a = ref_mem[rs1];
    b = ref_mem[rs2];
    carry = 1'b0; err = 1'b0; data = '0;
    if (op == OP_LDI) begin
      data = imm; lat = 2;
    end else if (ncoll > MR) begin
      err = 1'b1; lat = 3 + 2 * MR;
    end else begin
      lat = 4 + 2 * ncoll;
      case (op)
        OP_ADD: begin s = a + b; data = DW'(s % 65536); carry = (s >= 65536); end
        OP_SUB: begin s = a - b + 65536; data = DW'(s % 65536); carry = (b > a); end
        default: data = DW'(a);
      endcase
    end
    if (!err) ref_mem[rd] = data;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] imm, p1, p2;
    int            ncoll;
    logic [DW-1:0] e_data;
    logic          e_carry, e_err;
    int            e_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [1:0]    op;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] imm, e_data;
    logic          e_carry, e_err;
    int            ncoll, e_lat, r;

    //             op      rs1    rs2    rd     imm       p1        p2       nc  exp       c     e     lat
    vecs[0] = '{OP_LDI, 5'd0,  5'd0,  5'd1,  16'd30,   16'd0,    16'd0,    0, 16'd30,   1'b0, 1'b0, 2};
    vecs[1] = '{OP_ADD, 5'd0,  5'd1,  5'd2,  16'd0,    16'd100,  16'd20,   0, 16'd120,  1'b0, 1'b0, 4};
    vecs[2] = '{OP_SUB, 5'd3,  5'd4,  5'd5,  16'd0,    16'd20,   16'd40,   0, 16'hFFEC, 1'b1, 1'b0, 4};
    vecs[3] = '{OP_ADD, 5'd6,  5'd7,  5'd8,  16'd0,    16'hFFFF, 16'd1,    0, 16'd0,    1'b1, 1'b0, 4};
    vecs[4] = '{OP_MOV, 5'd16, 5'd9,  5'd10, 16'd0,    16'h1234, 16'd0,    1, 16'h1234, 1'b0, 1'b0, 6};
    vecs[5] = '{OP_ADD, 5'd11, 5'd12, 5'd13, 16'd0,    16'd5,    16'd6,    3, 16'd11,   1'b0, 1'b0, 10};
    vecs[6] = '{OP_ADD, 5'd15, 5'd17, 5'd14, 16'd0,    16'd7,    16'd8,    4, 16'd0,    1'b0, 1'b1, 9};
    vecs[7] = '{OP_LDI, 5'd0,  5'd0,  5'd0,  16'hFFFF, 16'd0,    16'd0,    0, 16'hFFFF, 1'b0, 1'b0, 2};
    vecs[8] = '{OP_SUB, 5'd18, 5'd18, 5'd18, 16'd0,    16'd9,    16'd9,    0, 16'd0,    1'b0, 1'b0, 4};
    vecs[9] = '{OP_SUB, 5'd19, 5'd20, 5'd19, 16'd0,    16'd0,    16'd1,    0, 16'hFFFF, 1'b1, 1'b0, 4};

    // Reset state with a command offered during reset.
    resetn = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_ADD; bus.cmd_rs1 = 5'd1;
    bus.cmd_rs2 = 5'd2; bus.cmd_rd = 5'd3; bus.cmd_imm = 16'hABCD;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.cmd_ready, 0);
    check("rst_rf", {bus.rf_ren1, bus.rf_ren2, bus.rf_wen1, bus.rf_rad1,
                     bus.rf_rad2, bus.rf_wad1, bus.rf_din}, 0);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_err}, 0);
    idle_cmd_inputs();
    @(negedge clk);
    resetn = 1'b1;

    // Directed table; LDI vector 7 is accepted right after the error response.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].op != OP_LDI) begin
        preload(vecs[i].rs1, vecs[i].p1);
        if (vecs[i].op != OP_MOV) preload(vecs[i].rs2, vecs[i].p2);
      end
      run_cmd(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm,
              vecs[i].ncoll, vecs[i].e_data, vecs[i].e_carry, vecs[i].e_err,
              vecs[i].e_lat);
    end

    // Reset in the middle of a command.
    reset_mid(1);
    reset_mid(2);

    // Randomized commands against the reference model.
    for (int a = 0; a < 32; a++) preload(AW'(a), DW'($urandom));
    for (int n = 0; n < 40; n++) begin
      op  = 2'($urandom_range(0, 3));
      rs1 = AW'($urandom_range(0, 31));
      rs2 = AW'($urandom_range(0, 31));
      rd  = AW'($urandom_range(0, 31));
      imm = DW'($urandom);
      r = $urandom_range(0, 9);
      ncoll = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 4;
      model(op, rs1, rs2, rd, imm, ncoll, e_data, e_carry, e_err, e_lat);
      run_cmd(op, rs1, rs2, rd, imm, ncoll, e_data, e_carry, e_err, e_lat);
    end

    // Register file contents must match the model after the random phase.
    @(negedge clk);
    begin
      int diffs;
      diffs = 0;
      for (int a = 0; a < 32; a++) if (rf_mem[a] !== ref_mem[a]) diffs++;
      check("rf_contents", diffs, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_cmd_master.md
Name: regfile_cmd_master

Overview:
Command-driven initiator for the two-read/one-write register file.
- Accepts one register-transfer command at a time over a valid/ready handshake.
- Issues the required reads on rad1/rad2, collects dout1/dout2 and computes the result.
- Writes the result back through wad1/din/wen1 and returns a one-cycle response.
- Sits between a control sequencer and the register file. It is the requester end of the register-file interface and retries reads that the file flags with collision.

Parameters:
DATA_WIDTH, 16, width of register data and immediate
ADDR_WIDTH, 5, register address width (32 entries)
MAX_RETRY, 3, read re-issues allowed on collision before error response

Ports:
clk  in  1  clock, all state updates on posedge
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept command (IDLE only)
cmd_op  in  2  00 ADD, 01 SUB, 10 MOV, 11 LDI
cmd_rs1  in  ADDR_WIDTH  source 1 address
cmd_rs2  in  ADDR_WIDTH  source 2 address
cmd_rd  in  ADDR_WIDTH  destination address
cmd_imm  in  DATA_WIDTH  immediate for LDI
rf_rad1  out  ADDR_WIDTH  read address 1
rf_ren1  out  1  read enable 1
rf_rad2  out  ADDR_WIDTH  read address 2
rf_ren2  out  1  read enable 2
rf_wad1  out  ADDR_WIDTH  write address
rf_wen1  out  1  write enable
rf_din  out  DATA_WIDTH  write data
rf_dout1  in  DATA_WIDTH  read data 1, valid one cycle after ren1
rf_dout2  in  DATA_WIDTH  read data 2, valid one cycle after ren2
rf_collision  in  1  read in previous cycle hit an in-flight write; dout invalid
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  DATA_WIDTH  value written (0 on error)
rsp_carry  out  1  ADD carry-out / SUB borrow; 0 for MOV/LDI
rsp_err  out  1  retries exhausted, no write performed

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, retry count=0, captured command cleared.
  - All rf_* and rsp_* outputs are 0; cmd_ready=0 while resetn=0.
  - A reset mid-operation aborts the operation; no write is issued after reset release.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted on the posedge with cmd_valid & cmd_ready. The op, rs1, rs2, rd and imm are captured at that edge.
- FSM states: IDLE, READ, WAIT, WRITE, RESP.
  - IDLE → READ on accept (ADD/SUB/MOV).
  - IDLE → WRITE on accept (LDI).
  - READ (1 cycle):
    - rf_ren1=1, rf_rad1=rs1.
    - rf_ren2=1 and rf_rad2=rs2 for ADD/SUB only.
    - → WAIT.
  - WAIT (1 cycle): samples rf_dout1/rf_dout2/rf_collision.
    - No collision: result computed and registered, → WRITE.
    - Collision with retry count < MAX_RETRY: count+1, → READ.
    - Collision with retry count = MAX_RETRY: → RESP with error.
  - WRITE (1 cycle): rf_wen1=1, rf_wad1=rd, rf_din=result. → RESP.
  - RESP (1 cycle): rsp_valid=1 with rsp_data/rsp_carry/rsp_err. Retry count cleared. → IDLE.
- Outside their states, all rf_* enables are 0 and addresses/data are 0. rsp_* outputs are 0 outside RESP.
- Arithmetic:
  - ADD = dout1+dout2 mod 2^DATA_WIDTH; carry = bit DATA_WIDTH of the sum.
  - SUB = dout1−dout2 mod 2^DATA_WIDTH; carry = 1 when dout2 > dout1 (unsigned borrow).
  - MOV = dout1.
  - LDI = imm.
- Latency, from accept edge to rsp_valid:
  - ADD/SUB/MOV: 4 cycles with no collision, plus 2 cycles per retry.
  - LDI: 2 cycles.
  - Error case: 3 + 2·MAX_RETRY cycles.
- Throughput: the next command can be accepted the cycle after RESP (IDLE).
- The block never asserts a read and wen1 in the same cycle. rs1/rs2 equal to rd is legal; the read-before-write order is guaranteed by the FSM.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- Reset value check: hold resetn=0 with cmd_valid=1 → cmd_ready=0, all rf_*/rsp_* = 0. Assert resetn=0 during WAIT → outputs 0 immediately; no rf_wen1 after release.
- LDI rd=1 imm=30 → rf_wen1 at accept+1 with wad1=1, din=30; rsp_valid at accept+2 with rsp_data=30, rsp_err=0.
- ADD rs1=0, rs2=1 with model dout1=100, dout2=20 → ren1=ren2=1 at accept+1; write din=120 wad1=rd at accept+3; rsp_valid at accept+4, rsp_carry=0.
- SUB with dout1=20, dout2=40 → rsp_data=0xFFEC, rsp_carry=1. ADD with 0xFFFF+0x0001 → rsp_data=0, rsp_carry=1.
- MOV rs1=16 → only ren1 asserted, rf_rad1=16, ren2=0. One collision in first WAIT → READ re-issued; rsp_valid at accept+6 with correct data.
- Collision held high for every WAIT → 4 read attempts total, no rf_wen1, rsp_valid at accept+9 with rsp_err=1, rsp_data=0. Next command accepted one cycle later.
